// File: rtl/obj_det_pkg.sv
// obj_det_pkg: shared types and coordinate-width helpers for the object detector
package obj_det_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  function automatic int xcoord_w(input int w);
    return $clog2(w);
  endfunction
  function automatic int ycoord_w(input int h);
    return $clog2(h);
  endfunction
endpackage

// File: rtl/bbox_accumulator.sv
// bbox_accumulator: running min/max of matching pixel coordinates; clear and update may coincide
module bbox_accumulator
  import obj_det_pkg::*;
#(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int XW = xcoord_w(W),
  parameter int YW = ycoord_w(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          update,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
);
  logic [XW-1:0] bx_min, bx_max, nx_min, nx_max;
  logic [YW-1:0] by_min, by_max, ny_min, ny_max;
  // A clear applies first so the SOF pixel itself can seed the box
  always_comb begin
    bx_min = clear ? XW'(W - 1) : x_min;
    bx_max = clear ? '0 : x_max;
    by_min = clear ? YW'(H - 1) : y_min;
    by_max = clear ? '0 : y_max;
    nx_min = (update && x < bx_min) ? x : bx_min;
    nx_max = (update && x > bx_max) ? x : bx_max;
    ny_min = (update && y < by_min) ? y : by_min;
    ny_max = (update && y > by_max) ? y : by_max;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
    end else begin
      x_min <= nx_min;
      x_max <= nx_max;
      y_min <= ny_min;
      y_max <= ny_max;
    end
  end
endmodule

// File: rtl/object_detector.sv
// object_detector: colour-window pixel counter with bounding box, reported once per completed frame
module object_detector
  import obj_det_pkg::*;
#(
  parameter int         IMG_WIDTH  = 640,
  parameter int         IMG_HEIGHT = 480,
  parameter int         MIN_PIXELS = 64,
  parameter logic [7:0] R_MIN      = 8'd160,
  parameter logic [7:0] G_MAX      = 8'd96,
  parameter logic [7:0] B_MAX      = 8'd96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iPixValid,
  input  logic                          iSOF,
  input  logic [23:0]                   iPixel,
  output logic                          oObjectDetected,
  output logic                          oFrameDone,
  output logic [$clog2(IMG_WIDTH)-1:0]  oXMin,
  output logic [$clog2(IMG_WIDTH)-1:0]  oXMax,
  output logic [$clog2(IMG_HEIGHT)-1:0] oYMin,
  output logic [$clog2(IMG_HEIGHT)-1:0] oYMax
);
  localparam int XW = xcoord_w(IMG_WIDTH);
  localparam int YW = ycoord_w(IMG_HEIGHT);
  localparam int CW = $clog2(MIN_PIXELS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MIN_PIXELS);
  state_t state, state_nxt;
  rgb_t pix;
  logic [XW-1:0] x, cx, bx_min, bx_max, xmin_q, xmax_q, lx_min, lx_max;
  logic [YW-1:0] y, cy, by_min, by_max, ymin_q, ymax_q, ly_min, ly_max;
  logic [CW-1:0] count;
  logic sof, scan_px, last, match, report, det_live, det_q, x_wrap;
  assign pix      = rgb_t'(iPixel);
  assign sof      = iPixValid & iSOF;
  assign scan_px  = iPixValid & ~iSOF & (state == SCAN);
  assign x_wrap   = x == XW'(IMG_WIDTH - 1);
  assign last     = scan_px & x_wrap & (y == YW'(IMG_HEIGHT - 1));
  assign match    = (sof | scan_px) & (pix.r >= R_MIN) & (pix.g <= G_MAX) & (pix.b <= B_MAX);
  assign cx       = sof ? '0 : x;
  assign cy       = sof ? '0 : y;
  assign report   = state == REPORT;
  assign det_live = count >= CMAX;
  assign lx_min   = det_live ? bx_min : '0;
  assign lx_max   = det_live ? bx_max : '0;
  assign ly_min   = det_live ? by_min : '0;
  assign ly_max   = det_live ? by_max : '0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // SOF restarts from any state, which also turns a mid-frame SOF into an abort
  always_comb begin
    state_nxt = sof ? SCAN : (state == SCAN) ? (last ? REPORT : SCAN) : IDLE;
  end
  always_comb begin
    oFrameDone      = report;
    oObjectDetected = report ? det_live : det_q;
    oXMin           = report ? lx_min : xmin_q;
    oXMax           = report ? lx_max : xmax_q;
    oYMin           = report ? ly_min : ymin_q;
    oYMax           = report ? ly_max : ymax_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      count  <= '0;
      det_q  <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      if (sof) begin
        x <= XW'(1);
        y <= '0;
      end else if (scan_px) begin
        x <= x_wrap ? '0 : x + 1'b1;
        y <= x_wrap ? y + 1'b1 : y;
      end
      count <= sof ? CW'(match) : count + CW'(match && count != CMAX);
      if (report) begin
        det_q  <= det_live;
        xmin_q <= lx_min;
        xmax_q <= lx_max;
        ymin_q <= ly_min;
        ymax_q <= ly_max;
      end
    end
  end
  bbox_accumulator #(.W(IMG_WIDTH), .H(IMG_HEIGHT), .XW(XW), .YW(YW)) u_bbox (
    .clk    (clk),
    .rst    (rst),
    .clear  (sof),
    .update (match),
    .x      (cx),
    .y      (cy),
    .x_min  (bx_min),
    .x_max  (bx_max),
    .y_min  (by_min),
    .y_max  (by_max)
  );
endmodule

// File: tb/tb_object_detector.sv
// tb_object_detector: directed frames on an 8x4 raster with hand-computed reports
module tb_object_detector;
  localparam int W = 8;
  localparam int H = 4;
  localparam int M = 3;
  logic clk = 1'b0;
  logic rst, v, sof;
  logic [23:0] pix;
  logic det, fd;
  logic [2:0] xmin, xmax;
  logic [1:0] ymin, ymax;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int base;
  logic [23:0] nonm [3] = '{24'h9F6060, 24'hFF6100, 24'hFF0061};

  object_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(M)) dut (
    .clk             (clk),
    .rst             (rst),
    .iPixValid       (v),
    .iSOF            (sof),
    .iPixel          (pix),
    .oObjectDetected (det),
    .oFrameDone      (fd),
    .oXMin           (xmin),
    .oXMax           (xmax),
    .oYMin           (ymin),
    .oYMax           (ymax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (fd) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input logic vv, input logic ss, input logic [23:0] p);
    v = vv;
    sof = ss;
    pix = p;
    @(negedge clk);
  endtask

  // Matches alternate between saturated red and the exact colour-window corner
  task automatic send_frame(input logic [31:0] mask, input bit gaps, input int n, input logic hold_det);
    for (int i = 0; i < n; i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) px(1'b0, 1'b1, 24'hFF0000);
      if (i == 31) begin
        chk("hold_det", det, hold_det);
        chk("no_early_done", fd, 0);
      end
      px(1'b1, i == 0, mask[i] ? ((i % 2) ? 24'hA06060 : 24'hFF0000) : nonm[i % 3]);
    end
  endtask

  task automatic check_report(input int d, input int x0, input int x1, input int y0, input int y1);
    chk("frame_done", fd, 1);
    chk("detect", det, d);
    chk("xmin", xmin, x0);
    chk("xmax", xmax, x1);
    chk("ymin", ymin, y0);
    chk("ymax", ymax, y1);
  endtask

  task automatic check_held(input int d, input int x0, input int x1, input int y0, input int y1);
    px(1'b0, 1'b0, 24'h0);
    chk("done_one_cycle", fd, 0);
    chk("held_detect", det, d);
    chk("held_xmin", xmin, x0);
    chk("held_xmax", xmax, x1);
    chk("held_ymin", ymin, y0);
    chk("held_ymax", ymax, y1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v = 1'b0;
    sof = 1'b0;
    pix = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      px(1'b1, 1'b1, 24'hFF0000);
      chk("rst_detect", det, 0);
      chk("rst_done", fd, 0);
      chk("rst_box", {xmin, xmax, ymin, ymax}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) px(1'b1, 1'b0, 24'hFF0000);
    chk("idle_drop_done", done_cnt, 0);
    chk("idle_drop_detect", det, 0);

    base = done_cnt;
    send_frame(32'h0008_2400, 1'b0, 32, 1'b0);
    check_report(1, 2, 5, 1, 2);
    check_held(1, 2, 5, 1, 2);
    chk("frame2_reports", done_cnt, base + 1);

    send_frame(32'h0100_0080, 1'b0, 32, 1'b1);
    check_report(0, 0, 0, 0, 0);
    check_held(0, 0, 0, 0, 0);

    base = done_cnt;
    send_frame(32'h0008_2400, 1'b1, 32, 1'b0);
    check_report(1, 2, 5, 1, 2);
    check_held(1, 2, 5, 1, 2);
    chk("gap_reports", done_cnt, base + 1);

    base = done_cnt;
    send_frame(32'hFFFF_FFFF, 1'b0, 17, 1'b1);
    chk("abort_held_xmin", xmin, 2);
    send_frame(32'h4010_0002, 1'b0, 32, 1'b1);
    check_report(1, 1, 6, 0, 3);
    check_held(1, 1, 6, 0, 3);
    chk("abort_reports", done_cnt, base + 1);

    base = done_cnt;
    send_frame(32'h0008_2400, 1'b0, 32, 1'b1);
    check_report(1, 2, 5, 1, 2);
    send_frame(32'hFFFF_FFFF, 1'b0, 32, 1'b1);
    check_report(1, 0, 7, 0, 3);
    check_held(1, 0, 7, 0, 3);
    chk("b2b_reports", done_cnt, base + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
